// File: rtl/kogge_stone_par.sv
// Registered N-bit Kogge-Stone parallel-prefix adder: {Cout, Sum} = A + B + Cin.
// Define KS_INPUT_REG_EN to add an input register stage (2-cycle latency instead of 1).
module kogge_stone_par #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    // Prefix positions: 0 holds Cin as a generate, positions 1..N hold operand bits 0..N-1.
    localparam int M = N + 1;
    localparam int L = $clog2(M);

    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         cin_in;

`ifdef KS_INPUT_REG_EN
    logic [N-1:0] a_d, a_q;
    logic [N-1:0] b_d, b_q;
    logic         cin_d, cin_q;

    always_comb begin
        a_d   = A;
        b_d   = B;
        cin_d = Cin;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
        end
    end

    assign a_in   = a_q;
    assign b_in   = b_q;
    assign cin_in = cin_q;
`else
    assign a_in   = A;
    assign b_in   = B;
    assign cin_in = Cin;
`endif

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [M-1:0] gl [0:L];
    logic [M-1:0] pl [0:L];
    logic [N-1:0] sum_d, sum_q;
    logic         cout_d, cout_q;

    always_comb begin
        g = a_in & b_in;
        p = a_in ^ b_in;
        for (int k = 0; k <= L; k++) begin
            gl[k] = '0;
            pl[k] = '0;
        end
        gl[0] = {g, cin_in};
        pl[0] = {p, 1'b0};
        // Each level doubles the span; nodes without a partner at distance 2^k pass through.
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < M; i++) begin
                if (i >= (1 << k)) begin
                    gl[k+1][i] = gl[k][i] | (pl[k][i] & gl[k][i - (1 << k)]);
                    pl[k+1][i] = pl[k][i] & pl[k][i - (1 << k)];
                end else begin
                    gl[k+1][i] = gl[k][i];
                    pl[k+1][i] = pl[k][i];
                end
            end
        end
        // gl[L][i] is the carry into operand bit i; gl[L][N] is the carry out.
        sum_d  = p ^ gl[L][N-1:0];
        cout_d = gl[L][N];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_kogge_stone_par.sv
// Bench for kogge_stone_par: directed table, reset sequences, exhaustive N=4 and random N=7/N=16.
// Latency follows KS_INPUT_REG_EN so the same bench covers both builds.
module tb_kogge_stone_par;

`ifdef KS_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic        c4 = 1'b0, cout4;
    logic [6:0]  a7 = '0, b7 = '0, sum7;
    logic        c7 = 1'b0, cout7;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        c16 = 1'b0, cout16;

    always #5 clk = ~clk;

    kogge_stone_par #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(c4), .Sum(sum4), .Cout(cout4)
    );
    kogge_stone_par #(.N(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .A(a7), .B(b7), .Cin(c7), .Sum(sum7), .Cout(cout7)
    );
    kogge_stone_par #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(c16), .Sum(sum16), .Cout(cout16)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [0:8];

    logic [4:0]  exp4_q  [$];
    string       tag4_q  [$];
    logic [7:0]  exp7_q  [$];
    logic [16:0] exp16_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare results that are due, then drive the next operands.
    // Driving rst=0 zeroes every expectation still in flight.
    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [4:0] e4, input string tag);
        logic [6:0]  ra7, rb7;
        logic        rc7;
        logic [15:0] ra16, rb16;
        logic        rc16;
        @(negedge clk);
        if (exp4_q.size() == LAT) check(tag4_q.pop_front(), {12'd0, cout4, sum4}, {12'd0, exp4_q.pop_front()});
        if (exp7_q.size() == LAT) check("rand_n7", {9'd0, cout7, sum7}, {9'd0, exp7_q.pop_front()});
        if (exp16_q.size() == LAT) check("rand_n16", {cout16, sum16}, exp16_q.pop_front());
        ra7  = 7'($urandom_range(0, 127));
        rb7  = 7'($urandom_range(0, 127));
        rc7  = 1'($urandom_range(0, 1));
        ra16 = 16'($urandom_range(0, 65535));
        rb16 = 16'($urandom_range(0, 65535));
        rc16 = 1'($urandom_range(0, 1));
        rst_n = rst;
        a4 = a;    b4 = b;    c4 = c;
        a7 = ra7;  b7 = rb7;  c7 = rc7;
        a16 = ra16; b16 = rb16; c16 = rc16;
        if (!rst) begin
            foreach (exp4_q[i]) exp4_q[i] = '0;
            foreach (exp7_q[i]) exp7_q[i] = '0;
            foreach (exp16_q[i]) exp16_q[i] = '0;
            exp4_q.push_back('0);
            exp7_q.push_back('0);
            exp16_q.push_back('0);
        end else begin
            exp4_q.push_back(e4);
            exp7_q.push_back({1'b0, ra7} + {1'b0, rb7} + {7'd0, rc7});
            exp16_q.push_back({1'b0, ra16} + {1'b0, rb16} + {16'd0, rc16});
        end
        tag4_q.push_back(tag);
    endtask

    function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {4'd0, c};
    endfunction

    initial begin
        logic [3:0] ra, rb;
        logic       rc;

        vecs[0] = '{4'b1101, 4'b1011, 1'b0, 4'b1000, 1'b1};
        vecs[1] = '{4'b0110, 4'b1001, 1'b0, 4'b1111, 1'b0};
        vecs[2] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
        vecs[3] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0};
        vecs[4] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
        vecs[5] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vecs[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
        vecs[7] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
        vecs[8] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0};

        // Reset held two cycles with random operands: outputs must stay zero.
        for (int i = 0; i < 2; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            step(1'b0, ra, rb, 1'b1, 5'd0, "reset");
        end

        // Directed table, applied back-to-back.
        for (int i = 0; i < 9; i++)
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum},
                 $sformatf("vec%0d", i));

        // Mid-stream reset discards the in-flight result; the first post-reset vector lands on time.
        step(1'b1, 4'b1111, 4'b1111, 1'b1, 5'b11111, "pre_rst");
        step(1'b0, 4'b1110, 4'b0111, 1'b1, 5'd0, "mid_rst");
        step(1'b1, 4'b0011, 4'b0100, 1'b1, 5'b01000, "post_rst0");
        step(1'b1, 4'b1001, 4'b1001, 1'b0, 5'b10010, "post_rst1");

        // Exhaustive N=4.
        for (int i = 0; i < 512; i++)
            step(1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8), model4(4'(i), 4'(i >> 4), 1'(i >> 8)), "exh_n4");

        // Random stream; N=7 and N=16 are driven randomly on every step.
        for (int i = 0; i < 10000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            step(1'b1, ra, rb, rc, model4(ra, rb, rc), "rand_n4");
        end

        for (int i = 0; i < LAT + 1; i++)
            step(1'b1, 4'd0, 4'd0, 1'b0, 5'd0, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kogge_stone_par.md
KOGGE_STONE_PAR -- requirements
Module: kogge_stone_par

Interface
REQ-001 Parameter: N, default 4, operand width in bits; legal range 2..64; non-power-of-two values SHALL be supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: A  input  N  addend A, unsigned.
REQ-005 Port: B  input  N  addend B, unsigned.
REQ-006 Port: Cin  input  1  carry-in to bit 0.
REQ-007 Port: Sum  output  N  registered sum bits [N-1:0].
REQ-008 Port: Cout  output  1  registered carry-out from bit N-1.

Function
REQ-009 Result SHALL satisfy {Cout, Sum} = A + B + Cin, computed modulo 2^(N+1) with no truncation of the carry.
REQ-010 Per-bit pre-processing SHALL form g[i] = A[i] & B[i] and p[i] = A[i] ^ B[i].
REQ-011 Carry computation SHALL be a Kogge-Stone parallel-prefix tree of ceil(log2(N+1)) levels with Cin treated as generate at position -1.
REQ-012 Level k of the tree SHALL combine node i with node i-2^k: G = Gi | (Pi & Gj), P = Pi & Pj.
REQ-013 Nodes with no partner at a given level SHALL pass through unchanged.
REQ-014 Post-processing SHALL form Sum[i] = p[i] ^ c[i], with c[0] = Cin and c[i] = group generate over bits [i-1:-1]; Cout = group generate over bits [N-1:-1].
REQ-015 The prefix tree SHALL be purely combinational between register stages; no ripple chain is permitted.
REQ-016 Latency without KS_INPUT_REG_EN: A, B and Cin sampled at rising edge t appear on Sum and Cout after edge t.
REQ-017 A new operand set SHALL be accepted every cycle; throughput is one addition per clock with no stall or handshake.
REQ-018 Boundary: all-ones + all-zeros + Cin=1 SHALL give Sum = 0 and Cout = 1.
REQ-019 Boundary: all-ones + all-ones + Cin=1 SHALL give Sum = all-ones and Cout = 1.

Reset
REQ-020 When rst_n = 0 at a rising clk edge, Sum SHALL become 0 and Cout SHALL become 0, as SHALL every internal pipeline register.
REQ-021 Reset SHALL take priority over data capture on the same edge.
REQ-022 The first valid result SHALL appear at the latency of REQ-016 or REQ-024, counted from the first edge with rst_n = 1.
REQ-023 Reset asserted mid-stream SHALL discard in-flight results; there is no asynchronous path.

Configuration
REQ-024 Macro KS_INPUT_REG_EN, when defined, SHALL add an input register stage on A, B and Cin, giving 2-cycle latency from sampling edge to output.
REQ-025 The input stage of REQ-024 SHALL be reset to 0 by rst_n.
REQ-026 Without KS_INPUT_REG_EN, inputs SHALL feed the prefix tree directly, giving 1-cycle latency.
REQ-027 Arithmetic results SHALL be identical in both builds; only latency differs.

Verification
REQ-028 Reset: hold rst_n = 0 for 2 cycles with random inputs -> Sum = 0000, Cout = 0.
REQ-029 N = 4, Cin = 0: (A, B) = (1101, 1011) -> Cout = 1, Sum = 1000; (0110, 1001) -> Cout = 0, Sum = 1111.
REQ-030 N = 4, Cin = 0: (1111, 0001) -> Cout = 1, Sum = 0000; (0101, 0011) -> Cout = 0, Sum = 1000; (1010, 0101) -> Cout = 0, Sum = 1111.
REQ-031 Carry-in: (1111, 0000, Cin = 1) -> Cout = 1, Sum = 0000; (1111, 1111, Cin = 1) -> Cout = 1, Sum = 1111.
REQ-032 Back-to-back: five vectors on consecutive cycles -> each result appears exactly at its latency, in order, in both builds.
REQ-033 Exhaustive for N = 4, plus 10k random vectors for N = 7 and N = 16 -> match the reference model of REQ-009 at the latency of the active build.
